// File: rtl/dsp48a1_pkg.sv
// Shared DSP48A1 slice definitions: OPMODE constants and the MAC sequencer state encoding.
package dsp48a1_pkg;

    // OPMODE = {D-op, pre-adder, carry-in, pre-adder en, Z[1:0], X[1:0]}
    localparam logic [7:0] OPM_ZERO      = 8'h00;
    localparam logic [7:0] OPM_MAC_FIRST = 8'h01;
    localparam logic [7:0] OPM_MAC_ACC   = 8'h09;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_ZERO  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mac_valid_delay.sv
// DEPTH-stage shift register of {valid, first} flags tracking products through the slice pipeline.
module mac_valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             v_in,
    input  logic             first_in,
    output logic [DEPTH-1:0] v_q,
    output logic [DEPTH-1:0] first_q
);

    // Bit i holds the flags of the product accepted i+1 cycles ago.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            v_q     <= '0;
            first_q <= '0;
        end else begin
            v_q[0]     <= v_in;
            first_q[0] <= first_in;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i]     <= v_q[i-1];
                first_q[i] <= first_q[i-1];
            end
        end
    end

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Control sequencer for a DSP48A1 slice used as a multiply-accumulator over LEN operand pairs.
module dsp48a1_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ce_ab,
    output logic             ce_m,
    output logic             ce_p,
    output logic             rst_p,
    output logic [7:0]       opmode,
    output logic             out_valid,
    output logic             done
);

    seq_state_t          state, state_nxt;
    logic [LEN_W-1:0]    remaining;
    logic                first_pend;
    logic [2:0]          drain_cnt;
    logic                accept, job_load, job_clr;
    logic [PIPE_LAT-1:0] dl_v, dl_first;
    logic                pre_v, pre_first;
    logic                unused_first_tail;

    always_ff @(posedge clk) begin
        if (rst) state <= SEQ_IDLE;
        else     state <= state_nxt;
    end

    // Handshake: an operand pair moves when in_valid && in_ready; abort wins over it.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        job_load  = 1'b0;
        job_clr   = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (start) begin
                    job_load  = 1'b1;
                    state_nxt = (len != '0) ? SEQ_RUN : SEQ_ZERO;
                end
            end
            SEQ_RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (remaining == LEN_W'(1)) state_nxt = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                if (drain_cnt == 3'(PIPE_LAT)) begin
                    out_valid = 1'b1;
                    done      = 1'b1;
                    state_nxt = SEQ_IDLE;
                end
            end
            SEQ_ZERO: begin
                done      = 1'b1;
                state_nxt = SEQ_IDLE;
            end
            default: state_nxt = SEQ_IDLE;
        endcase
        if (abort && state != SEQ_IDLE) begin
            accept    = 1'b0;
            out_valid = 1'b0;
            done      = 1'b0;
            job_clr   = 1'b1;
            state_nxt = SEQ_IDLE;
        end
    end

    assign busy  = (state != SEQ_IDLE);
    assign ce_ab = accept;

    mac_valid_delay #(.DEPTH(PIPE_LAT)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .clr      (job_clr),
        .v_in     (accept),
        .first_in (accept && first_pend),
        .v_q      (dl_v),
        .first_q  (dl_first)
    );

    // The tap one stage ahead of ce_p feeds the M enable and the opmode register.
    generate
        if (PIPE_LAT == 1) begin : g_tap_direct
            assign pre_v     = accept;
            assign pre_first = accept && first_pend;
        end else begin : g_tap_line
            assign pre_v     = dl_v[PIPE_LAT-2];
            assign pre_first = dl_first[PIPE_LAT-2];
        end
    endgenerate

    assign ce_m              = pre_v;
    assign ce_p              = dl_v[PIPE_LAT-1];
    assign unused_first_tail = dl_first[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining  <= '0;
            first_pend <= 1'b0;
            drain_cnt  <= 3'd0;
            rst_p      <= 1'b0;
            opmode     <= OPM_ZERO;
        end else begin
            rst_p <= job_load || job_clr;
            if (job_load) begin
                remaining  <= len;
                first_pend <= 1'b1;
            end else if (accept) begin
                remaining  <= remaining - LEN_W'(1);
                first_pend <= 1'b0;
            end
            drain_cnt <= (state == SEQ_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
            // Opmode only changes in the cycle before a P update, so it holds between products.
            if (pre_v) opmode <= pre_first ? OPM_MAC_FIRST : OPM_MAC_ACC;
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench: three sequencers (PIPE_LAT 1, 2, 4) driven in lockstep, checked against a scoreboard and a P-register model.
module tb_dsp48a1_mac_sequencer;

    localparam int NL        = 3;
    localparam int LEN_W     = 8;
    localparam int PLS [NL]  = '{1, 2, 4};

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             in_valid;

    logic       busy_w [NL];
    logic       in_ready_w [NL];
    logic       ce_ab_w [NL];
    logic       ce_m_w [NL];
    logic       ce_p_w [NL];
    logic       rst_p_w [NL];
    logic       out_valid_w [NL];
    logic       done_w [NL];
    logic [7:0] opmode_w [NL];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NL; g++) begin : lane
        dsp48a1_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PLS[g])) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .len       (len),
            .abort     (abort),
            .busy      (busy_w[g]),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .ce_ab     (ce_ab_w[g]),
            .ce_m      (ce_m_w[g]),
            .ce_p      (ce_p_w[g]),
            .rst_p     (rst_p_w[g]),
            .opmode    (opmode_w[g]),
            .out_valid (out_valid_w[g]),
            .done      (done_w[g])
        );
    end

    // Per-cycle stimulus events, written by the driver and consumed by the monitor
    bit          ev_start, ev_zero, ev_ready, ev_acc, ev_first, ev_last, ev_abort;
    logic [47:0] ev_prod, ev_sum;

    // Scoreboard: expected event cycles per lane
    int          cem_t_q [NL][$];
    int          cep_t_q [NL][$];
    logic [7:0]  op_q    [NL][$];
    int          rp_t_q  [NL][$];
    int          ov_t_q  [NL][$];
    int          done_t_q[NL][$];
    logic [47:0] exp_q   [NL][$];
    int          busy_from [NL];
    int          busy_to   [NL];
    logic [47:0] p_mod [NL];
    bit          hv [NL][5];
    logic [47:0] hp [NL][5];

    int checks   = 0;
    int failures = 0;
    bit prev_rst = 1'b0;
    bit end_req  = 1'b0;
    bit end_done = 1'b0;

    task automatic chk(input string name, input int l, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lane_pipe_lat=%0d cyc=%0d got=%0h expected=%0h", name, PLS[l], cyc, act, exp);
        end
    endtask

    initial begin
        for (int l = 0; l < NL; l++) begin
            busy_from[l] = 0;
            busy_to[l]   = -1;
            p_mod[l]     = '0;
        end
    end

    always @(negedge clk) begin
        int          pl;
        bit          e;
        logic [47:0] add;
        if (prev_rst) begin
            for (int l = 0; l < NL; l++)
                chk("reset_values", l, 48'({busy_w[l], in_ready_w[l], ce_ab_w[l], ce_m_w[l], ce_p_w[l],
                    rst_p_w[l], out_valid_w[l], done_w[l], opmode_w[l]}), 48'd0);
        end
        if (rst) begin
            for (int l = 0; l < NL; l++) begin
                cem_t_q[l].delete(); cep_t_q[l].delete(); op_q[l].delete(); rp_t_q[l].delete();
                ov_t_q[l].delete();  done_t_q[l].delete(); exp_q[l].delete();
                busy_to[l] = -1;
                for (int k = 0; k < 5; k++) hv[l][k] = 1'b0;
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                pl = PLS[l];
                for (int k = 4; k > 0; k--) begin
                    hv[l][k] = hv[l][k-1];
                    hp[l][k] = hp[l][k-1];
                end
                hv[l][0] = ev_acc;
                hp[l][0] = ev_prod;

                if (ev_start) begin
                    rp_t_q[l].push_back(cyc + 1);
                    busy_from[l] = cyc + 1;
                    busy_to[l]   = ev_zero ? cyc + 1 : 32'h7fff_ffff;
                    if (ev_zero) done_t_q[l].push_back(cyc + 1);
                end
                if (ev_acc) begin
                    cem_t_q[l].push_back(cyc + pl - 1);
                    cep_t_q[l].push_back(cyc + pl);
                    op_q[l].push_back(ev_first ? 8'h01 : 8'h09);
                    if (ev_last) begin
                        ov_t_q[l].push_back(cyc + pl + 1);
                        done_t_q[l].push_back(cyc + pl + 1);
                        exp_q[l].push_back(ev_sum);
                        busy_to[l] = cyc + pl + 1;
                    end
                end
                if (ev_abort) begin
                    while (cem_t_q[l].size() > 0 && cem_t_q[l][$] > cyc) void'(cem_t_q[l].pop_back());
                    while (cep_t_q[l].size() > 0 && cep_t_q[l][$] > cyc) begin
                        void'(cep_t_q[l].pop_back());
                        void'(op_q[l].pop_back());
                    end
                    ov_t_q[l].delete(); done_t_q[l].delete(); exp_q[l].delete();
                    rp_t_q[l].push_back(cyc + 1);
                    busy_to[l] = cyc;
                end

                chk("in_ready", l, 48'(in_ready_w[l]), 48'(ev_ready));
                chk("ce_ab", l, 48'(ce_ab_w[l]), 48'(ev_acc));
                chk("busy", l, 48'(busy_w[l]), 48'(cyc >= busy_from[l] && cyc <= busy_to[l]));

                e = (cem_t_q[l].size() > 0 && cem_t_q[l][0] == cyc);
                if (e) void'(cem_t_q[l].pop_front());
                chk("ce_m", l, 48'(ce_m_w[l]), 48'(e));

                e = (cep_t_q[l].size() > 0 && cep_t_q[l][0] == cyc);
                chk("ce_p", l, 48'(ce_p_w[l]), 48'(e));
                if (e) begin
                    chk("opmode", l, 48'(opmode_w[l]), 48'(op_q[l][0]));
                    void'(cep_t_q[l].pop_front());
                    void'(op_q[l].pop_front());
                end

                e = (rp_t_q[l].size() > 0 && rp_t_q[l][0] == cyc);
                if (e) void'(rp_t_q[l].pop_front());
                chk("rst_p", l, 48'(rst_p_w[l]), 48'(e));

                e = (ov_t_q[l].size() > 0 && ov_t_q[l][0] == cyc);
                chk("out_valid", l, 48'(out_valid_w[l]), 48'(e));
                if (e) begin
                    chk("p_sum", l, p_mod[l], exp_q[l][0]);
                    void'(ov_t_q[l].pop_front());
                    void'(exp_q[l].pop_front());
                end

                e = (done_t_q[l].size() > 0 && done_t_q[l][0] == cyc);
                if (e) void'(done_t_q[l].pop_front());
                chk("done", l, 48'(done_w[l]), 48'(e));

                // Slice P register: RSTP first, then CEP with the post-adder selected by opmode
                if (rst_p_w[l]) begin
                    p_mod[l] = '0;
                end else if (ce_p_w[l]) begin
                    add = hv[l][pl] ? hp[l][pl] : 48'h0bad_0000_0000;
                    if (opmode_w[l] == 8'h01)      p_mod[l] = add;
                    else if (opmode_w[l] == 8'h09) p_mod[l] = p_mod[l] + add;
                    else                           p_mod[l] = 48'hdead_dead_dead;
                end
            end
        end
        if (end_req && !end_done) begin
            for (int l = 0; l < NL; l++)
                chk("scoreboard_drained", l, 48'(cem_t_q[l].size() + cep_t_q[l].size() + rp_t_q[l].size()
                    + ov_t_q[l].size() + done_t_q[l].size()), 48'd0);
            end_done = 1'b1;
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        len      = LEN_W'($urandom);
        ev_start = 1'b0; ev_zero = 1'b0; ev_ready = 1'b0; ev_acc = 1'b0;
        ev_first = 1'b0; ev_last = 1'b0; ev_abort = 1'b0;
        ev_prod  = '0;   ev_sum  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            in_valid = 1'($urandom_range(0, 1));
        end
    endtask

    // mode: 0 always valid, 1 random bubbles, 2 two bubbles after the first accept,
    //       3 A=k+1 B=2 always valid, 4 A=5 B=6 always valid
    task automatic run_job(input int jlen, input int mode, input int abort_after,
                           input bit mid_start, input bit rst_drain);
        int          rem, nacc, gap;
        logic [47:0] sum, prod;
        logic [7:0]  a, b;
        bit          first;
        tick();
        start    = 1'b1;
        len      = LEN_W'(jlen);
        ev_start = 1'b1;
        ev_zero  = (jlen == 0);
        if (jlen == 0) begin
            idle(4);
            return;
        end
        rem = jlen; nacc = 0; gap = 0; sum = '0; first = 1'b1;
        while (rem > 0) begin
            tick();
            ev_ready = 1'b1;
            case (mode)
                1:       in_valid = ($urandom_range(0, 3) != 0);
                2: begin
                    if (nacc == 1 && gap < 2) begin
                        in_valid = 1'b0;
                        gap++;
                    end else in_valid = 1'b1;
                end
                default: in_valid = 1'b1;
            endcase
            a = (mode == 3) ? 8'(nacc + 1) : (mode == 4) ? 8'd5 : 8'($urandom);
            b = (mode == 3) ? 8'd2 : (mode == 4) ? 8'd6 : 8'($urandom);
            if (mid_start && nacc == 1) begin
                start = 1'b1;
                len   = LEN_W'(7);
            end
            if (abort_after >= 0 && nacc == abort_after) begin
                abort    = 1'b1;
                in_valid = 1'b1;
                ev_abort = 1'b1;
                break;
            end
            if (in_valid) begin
                prod     = 48'(a) * 48'(b);
                ev_acc   = 1'b1;
                ev_first = first;
                ev_prod  = prod;
                first    = 1'b0;
                sum      = sum + prod;
                rem--;
                nacc++;
                if (rem == 0) begin
                    ev_last = 1'b1;
                    ev_sum  = sum;
                end
            end
        end
        if (rst_drain && abort_after < 0) begin
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        idle(8);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        idle(2);

        run_job(4, 3, -1, 1'b0, 1'b0);   // four back-to-back products, sum 20
        run_job(3, 2, -1, 1'b0, 1'b0);   // two-cycle bubble mid-job
        run_job(0, 0, -1, 1'b0, 1'b0);   // zero-length job
        run_job(5, 0, 2, 1'b0, 1'b0);    // abort after two accepts
        run_job(1, 4, -1, 1'b0, 1'b0);   // follow-up single product 5*6
        run_job(3, 1, -1, 1'b1, 1'b0);   // start re-asserted mid-job is ignored
        run_job(4, 3, -1, 1'b0, 1'b1);   // reset while draining
        run_job(4, 3, -1, 1'b0, 1'b0);   // normal job right after that reset

        for (int j = 0; j < 30; j++) begin
            int jl, ab;
            jl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            ab = ($urandom_range(0, 5) == 0 && jl > 1) ? $urandom_range(0, jl - 1) : -1;
            run_job(jl, $urandom_range(0, 1), ab, 1'($urandom_range(0, 1)), 1'b0);
        end
        run_job(255, 1, -1, 1'b0, 1'b0); // longest job the length field allows

        end_req = 1'b1;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp48a1_mac_sequencer.md
Name: dsp48a1_mac_sequencer

Overview:
Controls one DSP48A1 slice configured as a multiply-accumulator and computes the sum of LEN products A*B.
- Accepts a job (start + len) and pulls operand pairs over a valid/ready stream.
- Drives the slice's clock enables and OPMODE so each product lands in the P accumulator on the correct cycle, then flags the final result.
- Operand data goes straight to the slice; this block carries control only.

Parameters:
LEN_W, 8, width of the job length (max LEN_W'(2^LEN_W-1) products per job).
PIPE_LAT, 2, register stages between the slice operand ports and the post-adder input (A1/B1 + MREG); legal range 1..4.

Ports:
clk  in  1  clock; all logic on its rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  job request; honoured only in IDLE.
len  in  LEN_W  number of products; sampled with start.
abort  in  1  synchronous job cancel.
busy  out  1  job in progress.
in_valid  in  1  operand pair present at slice A/B ports.
in_ready  out  1  sequencer can accept the operand pair.
ce_ab  out  1  A/B input-register clock enable.
ce_m  out  1  M-register clock enable.
ce_p  out  1  P-register clock enable.
rst_p  out  1  P-register clear, to the slice's synchronous RSTP.
opmode  out  8  slice OPMODE.
out_valid  out  1  one-cycle pulse: P holds the final sum.
done  out  1  one-cycle pulse: job finished (normal or zero-length).

Behaviour:
- Reset values: state IDLE; busy, in_ready, ce_ab, ce_m, ce_p, rst_p, out_valid, done = 0; opmode = 8'h00; delay line cleared.
- States:
  - IDLE: start && len!=0 -> RUN, loading remaining=len. start && len==0 -> ZERO.
  - ZERO: done=1 for one cycle, out_valid=0, then IDLE.
  - RUN: in_ready=1. Accept = in_valid && in_ready. Each accept decrements remaining. The accept that brings remaining to 0 -> DRAIN, with in_ready low from the next cycle.
  - DRAIN: counts PIPE_LAT cycles after the last accept. In cycle t_last+PIPE_LAT+1, out_valid=1 and done=1 for one cycle, then IDLE.
- busy is 1 in every non-IDLE state, including the out_valid/done cycle.
- ce_ab = accept (combinational from in_valid).
- Delay line: PIPE_LAT stages, each carrying {v, first}. Stage 0 input is {accept, accept is the job's first}.
  - ce_m = v at stage PIPE_LAT-1 (registered); for PIPE_LAT=1, ce_m = ce_ab.
  - ce_p = v at stage PIPE_LAT.
- opmode: registered, aligned with ce_p.
  - first product: 8'h01 (X=M, Z=0), starts a new sum.
  - later products: 8'h09 (X=M, Z=P), accumulate.
  - ce_p=0 cycles: opmode holds its last value.
- Bubbles (in_valid low in RUN) move through the delay line as v=0, so ce_m and ce_p drop in those cycles; P is unchanged.
- rst_p pulses one cycle when the job is accepted from IDLE. Harmless, since the first opmode ignores P, but it makes P read 0 during a job before the first product.
- abort (any non-IDLE state):
  - next cycle: IDLE; delay line cleared; ce_* = 0; rst_p = 1 for one cycle.
  - out_valid and done are never asserted for the aborted job.
  - abort has priority over accept in the same cycle.
- start while busy is ignored; len is not re-sampled.
- rst has priority over everything, including abort and start.
- Max throughput: one product per cycle. The next job's start is accepted in the cycle after done.

Decomposition:
- Shared package dsp48a1_pkg:
  - OPM_MAC_FIRST = 8'h01, OPM_MAC_ACC = 8'h09.
  - sequencer state encoding (IDLE, RUN, DRAIN, ZERO).
  - Lives alongside other slice OPMODE constants.
- Sub-module mac_valid_delay: parameterized PIPE_LAT-deep shift register of {v, first} with synchronous clear. Used for ce_m, ce_p and opmode alignment.

Test Plan:
1. len=4, PIPE_LAT=2, in_valid held high, A=1..4, B=2 -> ce_p high 4 consecutive cycles; opmode 01,09,09,09; out_valid 3 cycles after the last accept; P=20.
2. len=3 with in_valid low for 2 cycles between samples 1 and 2 -> ce_p shows the same 2-cycle gap; P=sum of products; exactly one out_valid.
3. len=0 -> done pulse one cycle after start; out_valid never asserted; busy high exactly 1 cycle.
4. abort after 2 of 5 accepts -> rst_p pulse; IDLE next cycle; no out_valid/done. A follow-up len=1 job (5*6) returns P=30.
5. start re-asserted mid-job with len=7 -> ignored; the original len=3 job completes with 3 accepts only.
6. rst asserted in DRAIN, and PIPE_LAT=1 and 4 variants of scenario 1 -> all outputs at reset values next cycle; out_valid offset tracks PIPE_LAT+1.
